// File: rtl/pc_seq_pkg.sv
// Shared definitions for the 3BC program-counter sequencer:
// FSM state encoding and the default widths and start address.
package pc_seq_pkg;

    localparam int PC_W_DEF     = 10;
    localparam int IDX_W_DEF    = 4;
    localparam int START_PC_DEF = 0;

    // Width of the optional run-length counter (PC_SEQ_CYCLE_CNT_EN builds).
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target calculator: turns the LUT value into either an absolute
// target or a signed PC-relative target, and flags relative results that
// fall outside the PC address space. Purely combinational.
module branch_target_calc
    import pc_seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] PC,
    input  logic [PC_W-1:0] LutOut,
    input  logic            BranchAbs,
    output logic [PC_W-1:0] Target,
    output logic            OutOfRange
);

    logic [PC_W:0] rel_sum;

    // Relative sum in PC_W+1 bits: the true result lies in
    // -2^(PC_W-1) .. 2^PC_W + 2^(PC_W-1) - 2, so after wrapping, the top bit
    // is set exactly when the result is negative or beyond the last address.
    always_comb begin
        rel_sum    = {LutOut[PC_W-1], LutOut} + {1'b0, PC};
        Target     = BranchAbs ? LutOut : rel_sum[PC_W-1:0];
        OutOfRange = !BranchAbs && rel_sum[PC_W];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the 3BC processor. Owns the PC register,
// the Start/Ack run handshake and the Fault flag, and drives the branch
// target LUT with the decoder's index field.
// Optional feature: define PC_SEQ_CYCLE_CNT_EN to add the 16-bit CycleCnt
// output (saturating count of RUN cycles, stalls included).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int START_PC = START_PC_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic             BranchAbs,
    input  logic [IDX_W-1:0] BranchIdx,
    input  logic             MemWait,
    output logic [IDX_W-1:0] LutIndex,
    input  logic [PC_W-1:0]  LutOut,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Ack,
    output logic             Fault
`ifdef PC_SEQ_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] CycleCnt
`endif
);

    localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;

    logic [PC_W-1:0] br_target;
    logic            br_out_of_range;

    // The LUT lookup is a same-cycle combinational path.
    assign LutIndex = BranchIdx;

    branch_target_calc #(
        .PC_W (PC_W)
    ) u_branch_target_calc (
        .PC         (pc_q),
        .LutOut     (LutOut),
        .BranchAbs  (BranchAbs),
        .Target     (br_target),
        .OutOfRange (br_out_of_range)
    );

    // Next-state, next-PC and fault logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = START_PC_V;
                    fault_d = 1'b0;
                end
            end

            ST_RUN: begin
                if (MemWait) begin
                    // Data memory busy: freeze everything this cycle.
                end else if (Halt) begin
                    state_d = ST_DONE;
                end else if (BranchEn) begin
                    if (br_out_of_range) begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        pc_d = br_target;
                    end
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                pc_d    = START_PC_V;
                fault_d = 1'b0;
            end
        endcase
    end

    // State, PC and fault registers with synchronous reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_PC_V;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign PC      = pc_q;
    assign Running = (state_q == ST_RUN);
    assign Ack     = (state_q == ST_DONE);
    assign Fault   = fault_q;

`ifdef PC_SEQ_CYCLE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Run-length counter: cleared when a run is accepted, counts every RUN
    // cycle (stalls too), saturates, and holds once the run ends.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_RUN) begin
            if (Start) begin
                cnt_d = '0;
            end
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CycleCnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed vector table walking
// through the run handshake, branch and stall corner cases, an optional
// CycleCnt sequence, and a randomized phase against a behavioural model.
module tb_pc_sequencer;

    localparam int PC_W  = 10;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             halt;
    logic             br_en;
    logic             br_abs;
    logic [IDX_W-1:0] br_idx;
    logic             mem_wait;
    logic [IDX_W-1:0] lut_index;
    logic [PC_W-1:0]  lut_out;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             ack;
    logic             fault;
`ifdef PC_SEQ_CYCLE_CNT_EN
    logic [15:0]      cycle_cnt;
`endif

    // Branch-target LUT modelled by the bench, addressed by the DUT.
    logic [PC_W-1:0] lut [16];
    assign lut_out = lut[lut_index];

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W     (PC_W),
        .IDX_W    (IDX_W),
        .START_PC (0)
    ) dut (
        .Clk       (clk),
        .Reset     (rst),
        .Start     (start),
        .Halt      (halt),
        .BranchEn  (br_en),
        .BranchAbs (br_abs),
        .BranchIdx (br_idx),
        .MemWait   (mem_wait),
        .LutIndex  (lut_index),
        .LutOut    (lut_out),
        .PC        (pc),
        .Running   (running),
        .Ack       (ack),
        .Fault     (fault)
`ifdef PC_SEQ_CYCLE_CNT_EN
        ,
        .CycleCnt  (cycle_cnt)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic h, input logic be,
                         input logic ba, input int idx, input logic mw);
        rst      = r;
        start    = s;
        halt     = h;
        br_en    = be;
        br_abs   = ba;
        br_idx   = IDX_W'(idx);
        mem_wait = mw;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst, start, halt, br_en, br_abs, mw;
        int   idx;
        int   exp_pc;
        logic exp_run, exp_ack, exp_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic h, input logic be,
                       input logic ba, input int idx, input logic mw,
                       input int epc, input logic erun, input logic eack, input logic eflt);
        vec_t v;
        v.rst = r; v.start = s; v.halt = h; v.br_en = be; v.br_abs = ba;
        v.idx = idx; v.mw = mw;
        v.exp_pc = epc; v.exp_run = erun; v.exp_ack = eack; v.exp_fault = eflt;
        vecs.push_back(v);
    endtask

    // Behavioural reference: run/done flags, PC as a plain integer.
    bit m_run, m_done, m_fault;
    int m_pc, m_cnt;

    function automatic int signed_lut(input int raw);
        return (raw >= 512) ? raw - 1024 : raw;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_run = 0; m_done = 0; m_fault = 0; m_pc = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_done = 0; m_fault = 0; m_pc = 0; m_cnt = 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt++;
            if (mem_wait) begin
                // stalled
            end else if (halt) begin
                m_run = 0; m_done = 1;
            end else if (br_en) begin
                if (br_abs) begin
                    m_pc = int'(lut[br_idx]);
                end else begin
                    int t;
                    t = m_pc + signed_lut(int'(lut[br_idx]));
                    if (t < 0 || t > 1023) begin
                        m_fault = 1; m_run = 0; m_done = 1;
                    end else begin
                        m_pc = t;
                    end
                end
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) lut[k] = '0;
        lut[1] = 10'd500;
        lut[2] = 10'd100;
        lut[3] = 10'd1023;
        lut[4] = 10'd7;
        lut[5] = 10'h268;   // -408 as a signed offset

        //   rst st hl be ba idx mw   pc   run ack flt
        add(1, 0, 0, 0, 0, 0, 0,    0,   0, 0, 0);  // reset state
        add(0, 1, 0, 0, 0, 0, 0,    0,   1, 0, 0);  // start accepted
        add(0, 0, 0, 0, 0, 0, 0,    1,   1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,    2,   1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,    3,   1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,    4,   1, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0,  500,   1, 0, 0);  // absolute -> 500
        add(0, 0, 0, 1, 0, 5, 0,   92,   1, 0, 0);  // 500 - 408
        add(0, 0, 0, 1, 1, 2, 0,  100,   1, 0, 0);  // absolute -> 100
        add(0, 0, 0, 1, 0, 5, 0,  100,   0, 1, 1);  // 100 - 408 faults
        add(0, 0, 0, 0, 0, 0, 0,  100,   0, 1, 1);  // DONE holds, fault sticky
        add(0, 1, 0, 0, 0, 0, 0,    0,   1, 0, 0);  // rerun clears fault
        add(0, 0, 0, 1, 1, 3, 0, 1023,   1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,    0,   1, 0, 0);  // 1023 wraps, no fault
        add(0, 0, 0, 1, 1, 4, 0,    7,   1, 0, 0);
        add(0, 0, 0, 1, 1, 1, 1,    7,   1, 0, 0);  // stall ignores branch
        add(0, 0, 0, 0, 0, 0, 1,    7,   1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1,    7,   1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,    8,   1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1,    8,   1, 0, 0);  // stall beats halt
        add(0, 0, 1, 0, 0, 0, 0,    8,   0, 1, 0);  // halt -> Ack
        add(0, 1, 0, 0, 0, 0, 0,    0,   1, 0, 0);  // back-to-back rerun
        add(0, 0, 0, 0, 0, 0, 0,    1,   1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0,    0,   0, 0, 0);  // reset beats start
        add(0, 0, 0, 0, 0, 0, 0,    0,   0, 0, 0);  // IDLE holds
        add(0, 1, 0, 0, 0, 0, 0,    0,   1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,    1,   1, 0, 0);  // start ignored in RUN
        add(0, 0, 0, 0, 0, 0, 1,    1,   1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1,    0,   0, 0, 0);  // reset mid-stall

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].halt, vecs[i].br_en,
                  vecs[i].br_abs, vecs[i].idx, vecs[i].mw);
            #1;
            check($sformatf("vec%0d lut_index", i), int'(lut_index), vecs[i].idx);
            step();
            check($sformatf("vec%0d pc", i),      int'(pc),      vecs[i].exp_pc);
            check($sformatf("vec%0d running", i), int'(running), int'(vecs[i].exp_run));
            check($sformatf("vec%0d ack", i),     int'(ack),     int'(vecs[i].exp_ack));
            check($sformatf("vec%0d fault", i),   int'(fault),   int'(vecs[i].exp_fault));
        end

`ifdef PC_SEQ_CYCLE_CNT_EN
        // Five RUN cycles (four increments plus the halt cycle).
        drive(1, 0, 0, 0, 0, 0, 0); step();
        check("cnt reset", int'(cycle_cnt), 0);
        drive(0, 1, 0, 0, 0, 0, 0); step();
        check("cnt cleared on start", int'(cycle_cnt), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step();
        drive(0, 0, 1, 0, 0, 0, 0); step();
        check("cnt after 5-cycle run", int'(cycle_cnt), 5);
        check("cnt run ack", int'(ack), 1);
        drive(0, 0, 0, 0, 0, 0, 0); step(); step();
        check("cnt held in DONE", int'(cycle_cnt), 5);
        drive(0, 1, 0, 0, 0, 0, 0); step();
        check("cnt cleared on rerun", int'(cycle_cnt), 0);
`endif

        // Randomized phase against the behavioural model.
        for (int k = 0; k < 16; k++) lut[k] = PC_W'($urandom);
        drive(1, 0, 0, 0, 0, 0, 0);
        model_edge();
        step();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15),
                  $urandom_range(0, 5) == 0);
            model_edge();
            step();
            check($sformatf("rnd%0d pc", c),      int'(pc),      m_pc);
            check($sformatf("rnd%0d running", c), int'(running), int'(m_run));
            check($sformatf("rnd%0d ack", c),     int'(ack),     int'(m_done));
            check($sformatf("rnd%0d fault", c),   int'(fault),   int'(m_fault));
`ifdef PC_SEQ_CYCLE_CNT_EN
            check($sformatf("rnd%0d cnt", c),     int'(cycle_cnt), m_cnt);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
